// File: rtl/volume_control_mc_pkg.sv
// volume_pkg: shared key FSM states and saturating step arithmetic for the
// multi-channel volume controller.
package volume_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;

    // Operands are widened to 32 bits so the sum never wraps before clamping.
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] step,
                                            input logic [31:0] lim);
        return (v + step > lim) ? lim : v + step;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] v, input logic [31:0] step);
        return (v < step) ? 32'd0 : v - step;
    endfunction

endpackage

// File: rtl/volume_control_mc_ramp.sv
// vol_ramp: per-channel slew limiter, moving the output one LSB toward the
// effective target on every prescaler tick.
module vol_ramp
    import volume_pkg::*;
#(
    parameter int VOL_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_tick,
    input  logic [VOL_W-1:0] i_tgt,
    output logic [VOL_W-1:0] o_lvl,
    output logic             o_busy
);

    logic [VOL_W-1:0] r_lvl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_lvl <= '0;
        else if (i_tick && r_lvl != i_tgt)
            r_lvl <= (r_lvl < i_tgt) ? r_lvl + 1'b1 : r_lvl - 1'b1;
    end

    assign o_lvl  = r_lvl;
    assign o_busy = r_lvl != i_tgt;

endmodule

// File: rtl/volume_control_mc.sv
// volume_control_mc: held-key volume stepping with auto-repeat, per-channel
// saturating targets, mute flags and slew-limited output levels.
module volume_control_mc
    import volume_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int VOL_W      = 8,
    parameter int VOL_MAX    = 80,
    parameter int STEP       = 4,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 10_000_000,
    parameter int RAMP_DIV   = 4096,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      vol_cng_i,
    input  logic                      vol_cng_val_i,
    input  logic [CH_W-1:0]           ch_sel_i,
    input  logic                      mute_tgl_i,
    output logic [CHANNELS*VOL_W-1:0] tgt_lvl_o,
    output logic [CHANNELS*VOL_W-1:0] vol_lvl_o,
    output logic [CHANNELS-1:0]       mute_o,
    output logic [CHANNELS-1:0]       ramp_busy_o
);

    localparam int CNT_W = $clog2((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER) + 1;
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [CH_W-1:0]  r_ch;
    logic [PRE_W-1:0] r_pre;
    logic [VOL_W-1:0] r_tgt [CHANNELS];
    logic [CHANNELS-1:0] r_mute;

    logic             w_step;
    logic             w_up;
    logic [CH_W-1:0]  w_ch;
    logic             w_tick;
    logic [VOL_W-1:0] w_eff [CHANNELS];

    // A release wins over a maturing counter because every step term needs val.
    assign w_step = vol_cng_val_i && (r_state == IDLE ||
                    (r_state == DELAY  && r_cnt == CNT_W'(REPEAT_DLY - 1)) ||
                    (r_state == REPEAT && r_cnt == CNT_W'(REPEAT_PER - 1)));
    assign w_up   = (r_state == IDLE) ? vol_cng_i : r_dir;
    assign w_ch   = (r_state == IDLE) ? ch_sel_i  : r_ch;
    assign w_tick = r_pre == PRE_W'(RAMP_DIV - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_ch    <= '0;
        end else begin
            r_state <= !vol_cng_val_i ? IDLE :
                       (r_state == IDLE) ? DELAY :
                       (r_state == DELAY) ? (w_step ? REPEAT : DELAY) : REPEAT;
            r_cnt   <= (!vol_cng_val_i || w_step) ? '0 : r_cnt + 1'b1;
            if (r_state == IDLE) begin
                r_dir <= vol_cng_i;
                r_ch  <= ch_sel_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_pre <= '0;
        else
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    // An up-step clears mute and takes priority over a same-cycle toggle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) r_tgt[c] <= '0;
            r_mute <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_step && w_ch == CH_W'(c))
                    r_tgt[c] <= w_up ? VOL_W'(sat_add(32'(r_tgt[c]), STEP, VOL_MAX))
                                     : VOL_W'(sat_sub(32'(r_tgt[c]), STEP));
                r_mute[c] <= (w_step && w_up && w_ch == CH_W'(c)) ? 1'b0 :
                             (mute_tgl_i && ch_sel_i == CH_W'(c)) ? ~r_mute[c] : r_mute[c];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_eff[g] = r_mute[g] ? '0 : r_tgt[g];
        assign tgt_lvl_o[g*VOL_W +: VOL_W] = r_tgt[g];
        vol_ramp #(.VOL_W(VOL_W)) u_ramp (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .i_tick (w_tick),
            .i_tgt  (w_eff[g]),
            .o_lvl  (vol_lvl_o[g*VOL_W +: VOL_W]),
            .o_busy (ramp_busy_o[g])
        );
    end

    assign mute_o = r_mute;

endmodule

// File: tb/tb_volume_control_mc.sv
// tb_volume_control_mc: directed and random key/mute stimulus on two instances
// (limits 80 and 82) checked against a hold-time based reference model.
module tb_volume_control_mc;

    localparam int DLY  = 8;
    localparam int PER  = 3;
    localparam int STEP = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       vol_cng_i = 1'b0;
    logic       vol_cng_val_i = 1'b0;
    logic [0:0] ch_sel_i = 1'b0;
    logic       mute_tgl_i = 1'b0;
    logic [15:0] tgt_o  [2];
    logic [15:0] vol_o  [2];
    logic [1:0]  mute_o [2];
    logic [1:0]  busy_o [2];

    int n_vec = 0;
    int n_err = 0;

    int  m_tgt  [2][2];
    int  m_lvl  [2][2];
    bit  m_mute [2][2];
    bit  m_held;
    int  m_k;
    bit  m_dir;
    int  m_ch;

    always #5 clk_i = ~clk_i;

    volume_control_mc #(.CHANNELS(2), .VOL_W(8), .VOL_MAX(80), .STEP(STEP),
                        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .RAMP_DIV(1)) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .vol_cng_i(vol_cng_i), .vol_cng_val_i(vol_cng_val_i),
        .ch_sel_i(ch_sel_i), .mute_tgl_i(mute_tgl_i), .tgt_lvl_o(tgt_o[0]),
        .vol_lvl_o(vol_o[0]), .mute_o(mute_o[0]), .ramp_busy_o(busy_o[0]));

    volume_control_mc #(.CHANNELS(2), .VOL_W(8), .VOL_MAX(82), .STEP(STEP),
                        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .RAMP_DIV(1)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .vol_cng_i(vol_cng_i), .vol_cng_val_i(vol_cng_val_i),
        .ch_sel_i(ch_sel_i), .mute_tgl_i(mute_tgl_i), .tgt_lvl_o(tgt_o[1]),
        .vol_lvl_o(vol_o[1]), .mute_o(mute_o[1]), .ramp_busy_o(busy_o[1]));

    function automatic int vmax(input int i);
        return (i == 0) ? 80 : 82;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) begin
                m_tgt[i][c] = 0; m_lvl[i][c] = 0; m_mute[i][c] = 0;
            end
        m_held = 0; m_k = 0; m_dir = 0; m_ch = 0;
    endtask

    // Steps fall at hold ages 0, DLY, DLY+PER, ... counted from the press edge.
    task automatic m_edge(input bit v, input bit d, input int ch, input bit t);
        bit step;
        int eff;
        step = 0;
        if (v) begin
            if (!m_held) begin
                m_held = 1; m_k = 0; m_dir = d; m_ch = ch; step = 1;
            end else begin
                m_k++;
                step = (m_k >= DLY) && ((m_k - DLY) % PER == 0);
            end
        end else m_held = 0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) begin
                eff = m_mute[i][c] ? 0 : m_tgt[i][c];
                if (m_lvl[i][c] < eff) m_lvl[i][c]++;
                else if (m_lvl[i][c] > eff) m_lvl[i][c]--;
                if (t && ch == c) m_mute[i][c] = !m_mute[i][c];
                if (step && m_ch == c) begin
                    if (m_dir) begin
                        m_tgt[i][c] = (m_tgt[i][c] + STEP > vmax(i)) ? vmax(i) : m_tgt[i][c] + STEP;
                        m_mute[i][c] = 0;
                    end else
                        m_tgt[i][c] = (m_tgt[i][c] < STEP) ? 0 : m_tgt[i][c] - STEP;
                end
            end
    endtask

    task automatic check_all();
        int eff;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) begin
                eff = m_mute[i][c] ? 0 : m_tgt[i][c];
                chk($sformatf("tgt%0d_ch%0d", i, c), 32'(tgt_o[i][c*8 +: 8]), m_tgt[i][c]);
                chk($sformatf("vol%0d_ch%0d", i, c), 32'(vol_o[i][c*8 +: 8]), m_lvl[i][c]);
                chk($sformatf("mute%0d_ch%0d", i, c), 32'(mute_o[i][c]), 32'(m_mute[i][c]));
                chk($sformatf("busy%0d_ch%0d", i, c), 32'(busy_o[i][c]), 32'(m_lvl[i][c] != eff));
            end
    endtask

    task automatic cyc(input bit v, input bit d, input bit ch, input bit t);
        vol_cng_val_i = v; vol_cng_i = d; ch_sel_i = ch; mute_tgl_i = t;
        @(posedge clk_i);
        m_edge(v, d, int'(ch), t);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b1;
        #1 m_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic tap(input bit d, input bit ch);
        cyc(1'b1, d, ch, 1'b0);
        cyc(1'b0, d, ch, 1'b0);
    endtask

    initial begin
        int run;
        bit rv;
        m_reset();
        #2 check_all();
        @(negedge clk_i);
        rst_i = 1'b0;

        cyc(1, 1, 1, 0);
        chk("single_tgt", 32'(tgt_o[0]), 32'h0400);
        chk("single_busy", 32'(busy_o[0]), 32'b10);
        repeat (4) cyc(0, 0, 0, 0);
        chk("single_vol", 32'(vol_o[0][15:8]), 4);
        chk("single_idle", 32'(busy_o[0]), 0);

        do_reset();
        for (int k = 0; k <= 20; k++) cyc(1, k < 5, k >= 5, 0);
        cyc(0, 1, 0, 0);
        chk("repeat_tgt", 32'(tgt_o[0]), 24);

        do_reset();
        for (int k = 0; k < 20; k++) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("release_blocks", 32'(tgt_o[0]), 20);

        do_reset();
        for (int k = 0; k <= 59; k++) cyc(1, 1, 0, 0);
        chk("sat_76", 32'(tgt_o[1][7:0]), 76);
        for (int k = 60; k <= 70; k++) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("sat_80", 32'(tgt_o[0][7:0]), 80);
        chk("sat_82", 32'(tgt_o[1][7:0]), 82);
        repeat (22) tap(0, 0);
        chk("down_floor_a", 32'(tgt_o[0][7:0]), 0);
        chk("down_floor_b", 32'(tgt_o[1][7:0]), 0);

        do_reset();
        repeat (10) tap(1, 0);
        repeat (45) cyc(0, 0, 0, 0);
        chk("mute_pre_vol", 32'(vol_o[0][7:0]), 40);
        cyc(0, 0, 0, 1);
        chk("mute_on", 32'(mute_o[0]), 1);
        repeat (42) cyc(0, 0, 0, 0);
        chk("mute_vol0", 32'(vol_o[0][7:0]), 0);
        chk("mute_keep_tgt", 32'(tgt_o[0][7:0]), 40);
        tap(1, 0);
        chk("unmute", 32'(mute_o[0]), 0);
        chk("unmute_tgt", 32'(tgt_o[0][7:0]), 44);
        repeat (46) cyc(0, 0, 0, 0);
        chk("unmute_vol", 32'(vol_o[0][7:0]), 44);

        cyc(1, 1, 0, 1);
        chk("simul_mute", 32'(mute_o[0]), 0);
        chk("simul_tgt", 32'(tgt_o[0][7:0]), 48);
        cyc(0, 0, 0, 0);

        cyc(1, 1, 1, 0);
        repeat (2) cyc(1, 1, 1, 0);
        do_reset();
        cyc(1, 1, 1, 0);
        chk("post_reset_step", 32'(tgt_o[0]), 32'h0400);
        cyc(0, 0, 0, 0);

        run = 0;
        rv = 0;
        for (int n = 0; n < 600; n++) begin
            if (run == 0) begin
                rv  = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 30);
            end
            run--;
            cyc(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
